dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data_memory port between two requesters: port 0 is the processor load/store stage,
//  port 1 is the serial loader/debug engine. Sits between both requesters and data_memory.
//  Runs a req/done handshake per port, arbitrates, issues one memory command, waits the memory latency
//  and returns read data. One transaction in flight at a time.
// PARAMETERS
//  MEM_LATENCY  1  cycles from command-issue cycle to readdata_in valid; legal 1..7
// PORTS
//  clock          in   1   single clock; all state updates on rising edge
//  reset          in   1   synchronous, active-high
//  req0_in        in   1   port 0 request; held high until done0_out
//  addr0_in       in   32  port 0 byte address
//  wdata0_in      in   32  port 0 write data
//  we0_in         in   1   port 0: 1=write, 0=read
//  size0_in       in   2   port 0 access size, passed to memory unchanged
//  done0_out      out  1   one-cycle pulse: port 0 transaction complete
//  rdata0_out     out  32  port 0 read data; valid with done0_out, held until next port-0 done
//  req1_in/addr1_in/wdata1_in/we1_in/size1_in/done1_out/rdata1_out  same as port 0, for port 1
//  mem_addr_out   out  32  to data_memory addr_in
//  mem_wdata_out  out  32  to data_memory writedata_in
//  mem_re_out     out  1   to data_memory re_in
//  mem_we_out     out  1   to data_memory we_in
//  mem_size_out   out  2   to data_memory size_in
//  mem_rdata_in   in   32  from data_memory readdata_out
//  busy_out       out  1   1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=1, counter=0; every output 0 (done, rdata, mem_*, busy).
//  - States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Every output is registered.
//  - IDLE: sample req0/req1. If neither is high, stay in IDLE. Otherwise:
//    pick the winner, latch its addr/wdata/we/size into the mem_* registers, and go to ISSUE.
//  - Round-robin: if both requests are high, grant the port != last_grant. A single request always wins.
//    last_grant is updated at grant time. After reset, port 0 wins the first tie.
//  - ISSUE (1 cycle): mem_re_out=~we and mem_we_out=we, each high for exactly this cycle.
//    mem_addr/wdata/size stay stable from ISSUE through DONE. Load counter=MEM_LATENCY-1.
//  - WAIT: decrement counter each cycle. When counter==0, capture mem_rdata_in into the winner's rdata.
//    For a write, the winner's rdata is left unchanged. Go to DONE.
//    With MEM_LATENCY=1, WAIT lasts exactly 1 cycle.
//  - DONE (1 cycle): the winner's done pulses; the other port's done stays 0. mem_re/we=0. Next state IDLE.
//  - Latency: req sampled in IDLE at cycle N -> ISSUE at N+1 -> done at N+2+MEM_LATENCY.
//    Writes use the same timing as reads.
//  - Handshake: the requester drops req on the cycle after done (registered response).
//    A req still high in the following IDLE starts a new transaction.
//    The losing port's req stays pending; it is not dropped or acknowledged.
//  - Requester inputs are ignored outside IDLE; only the latched copy drives memory.
//  - Back-to-back traffic: minimum 3+MEM_LATENCY cycles per transaction. The IDLE bubble is required.
//  - Reset mid-operation aborts the transaction: no done pulse; a write already issued is not undone.
//  - Never assert mem_re_out and mem_we_out together. Never assert both done outputs in the same cycle.
// CONFIGURATION
//  - DMEM_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins ties.
//    last_grant still updates but does not affect selection.
//  - DMEM_ARB_FIXED_PRIO_EN undefined (default): round-robin as specified above.
// TESTING
//  1. Reset held 2 cycles, then released with both reqs low -> all outputs 0, busy 0, state stays IDLE.
//  2. Port 0 read of addr 0x10 with memory returning 0xDEADBEEF, LAT=1:
//     mem_re pulses at N+1, done0 at N+3, rdata0=0xDEADBEEF.
//  3. Port 1 write of 0xCAFEF00D to 0x20, size=2'b10: mem_we pulses for exactly 1 cycle with addr/data/size matching;
//     done1 pulses; rdata1 unchanged.
//  4. Both reqs held continuously after reset -> grants alternate 0,1,0,1.
//     With DMEM_ARB_FIXED_PRIO_EN defined -> grants are 0,0,0,0.
//  5. MEM_LATENCY=4, port 0 read -> done0 exactly 6 cycles after the IDLE sample cycle.
//     Changing addr0_in during WAIT does not alter mem_addr_out.
//  6. Reset asserted during WAIT -> no done pulse; next cycle all outputs 0, busy 0.
//     A fresh request then completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data_memory port between the load/store stage (port 0) and the loader/debug engine (port 1).
// Latency: request sampled in IDLE at N -> memory command at N+1 -> done pulse at N+2+MEM_LATENCY; at least 3+MEM_LATENCY cycles per transaction.
// Backpressure: one transaction in flight; a losing request stays pending until granted. `DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority.
module dmem_arbiter #(
   parameter int MEM_LATENCY = 1   // cycles from command issue to valid read data, 1..7
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_in,
   input  logic [31:0] addr0_in,
   input  logic [31:0] wdata0_in,
   input  logic        we0_in,
   input  logic [1:0]  size0_in,
   output logic        done0_out,
   output logic [31:0] rdata0_out,
   input  logic        req1_in,
   input  logic [31:0] addr1_in,
   input  logic [31:0] wdata1_in,
   input  logic        we1_in,
   input  logic [1:0]  size1_in,
   output logic        done1_out,
   output logic [31:0] rdata1_out,
   output logic [31:0] mem_addr_out,
   output logic [31:0] mem_wdata_out,
   output logic        mem_re_out,
   output logic        mem_we_out,
   output logic [1:0]  mem_size_out,
   input  logic [31:0] mem_rdata_in,
   output logic        busy_out
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

   // WAIT spends MEM_LATENCY cycles, counting down to zero inclusive
   localparam logic [2:0] CNT_LOAD = 3'(MEM_LATENCY - 1);

   state_t      state, state_nxt;
   logic        last_grant, last_grant_nxt;
   logic        owner, owner_nxt;       // port being served
   logic        op_we, op_we_nxt;       // latched direction of the transaction
   logic [2:0]  cnt, cnt_nxt;
   logic        pick;                   // winner if a grant happens this cycle
   logic [31:0] addr_nxt, wdata_nxt;
   logic [1:0]  size_nxt;
   logic        re_nxt, we_nxt;
   logic        done0_nxt, done1_nxt;
   logic [31:0] rdata0_nxt, rdata1_nxt;
   logic        busy_nxt;

`ifdef DMEM_ARB_FIXED_PRIO_EN
   // Port 0 always wins; last_grant is tracked but not consulted
   assign pick = req0_in ? 1'b0 : 1'b1;
`else
   // On a tie serve the port that did not win last time; a lone request always wins
   assign pick = (req0_in && req1_in) ? ~last_grant : req1_in;
`endif

   // Next-state and next-output logic; every output is registered from these values
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      owner_nxt      = owner;
      op_we_nxt      = op_we;
      cnt_nxt        = cnt;
      addr_nxt       = mem_addr_out;
      wdata_nxt      = mem_wdata_out;
      size_nxt       = mem_size_out;
      re_nxt         = 1'b0;
      we_nxt         = 1'b0;
      done0_nxt      = 1'b0;
      done1_nxt      = 1'b0;
      rdata0_nxt     = rdata0_out;
      rdata1_nxt     = rdata1_out;
      case (state)
         ST_IDLE: begin
            if (req0_in || req1_in) begin
               owner_nxt      = pick;
               last_grant_nxt = pick;
               if (pick) begin
                  addr_nxt  = addr1_in;
                  wdata_nxt = wdata1_in;
                  size_nxt  = size1_in;
                  op_we_nxt = we1_in;
               end else begin
                  addr_nxt  = addr0_in;
                  wdata_nxt = wdata0_in;
                  size_nxt  = size0_in;
                  op_we_nxt = we0_in;
               end
               re_nxt    = ~op_we_nxt;
               we_nxt    = op_we_nxt;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_nxt   = CNT_LOAD;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt == 3'd0) begin
               // Writes leave the owner's read data untouched
               if (!op_we) begin
                  if (owner) rdata1_nxt = mem_rdata_in;
                  else       rdata0_nxt = mem_rdata_in;
               end
               done0_nxt = ~owner;
               done1_nxt = owner;
               state_nxt = ST_DONE;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign busy_nxt = (state_nxt != ST_IDLE);

   // State and output registers; reset aborts any transaction without a done pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_IDLE;
         last_grant    <= 1'b1;
         owner         <= 1'b0;
         op_we         <= 1'b0;
         cnt           <= 3'd0;
         mem_addr_out  <= '0;
         mem_wdata_out <= '0;
         mem_size_out  <= '0;
         mem_re_out    <= 1'b0;
         mem_we_out    <= 1'b0;
         done0_out     <= 1'b0;
         done1_out     <= 1'b0;
         rdata0_out    <= '0;
         rdata1_out    <= '0;
         busy_out      <= 1'b0;
      end else begin
         state         <= state_nxt;
         last_grant    <= last_grant_nxt;
         owner         <= owner_nxt;
         op_we         <= op_we_nxt;
         cnt           <= cnt_nxt;
         mem_addr_out  <= addr_nxt;
         mem_wdata_out <= wdata_nxt;
         mem_size_out  <= size_nxt;
         mem_re_out    <= re_nxt;
         mem_we_out    <= we_nxt;
         done0_out     <= done0_nxt;
         done1_out     <= done1_nxt;
         rdata0_out    <= rdata0_nxt;
         rdata1_out    <= rdata1_nxt;
         busy_out      <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives dmem_arbiter with directed and random requester traffic and a simple memory.
// Main instance uses latency 1; a second instance with latency 4 covers the long-wait timing.
// Expected outputs come from a transaction-level model keyed on grant cycle numbers.
module tb_dmem_arbiter;

   localparam int LAT = 1;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   // main instance signals
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [1:0]  size0, size1;
   logic [31:0] mem_rdata;
   logic        done0, done1, mem_re, mem_we, busy;
   logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
   logic [1:0]  mem_size;

   // latency-4 instance signals
   logic        q_req0, q_we0;
   logic [31:0] q_addr0, q_wdata0, q_mem_rdata;
   logic [1:0]  q_size0;
   logic        q_done0, q_done1, q_mem_re, q_mem_we, q_busy;
   logic [31:0] q_rdata0, q_rdata1, q_mem_addr, q_mem_wdata;
   logic [1:0]  q_mem_size;

   dmem_arbiter #(.MEM_LATENCY(LAT)) dut (
      .clock(clock), .reset(reset),
      .req0_in(req0), .addr0_in(addr0), .wdata0_in(wdata0), .we0_in(we0), .size0_in(size0),
      .done0_out(done0), .rdata0_out(rdata0),
      .req1_in(req1), .addr1_in(addr1), .wdata1_in(wdata1), .we1_in(we1), .size1_in(size1),
      .done1_out(done1), .rdata1_out(rdata1),
      .mem_addr_out(mem_addr), .mem_wdata_out(mem_wdata), .mem_re_out(mem_re), .mem_we_out(mem_we),
      .mem_size_out(mem_size), .mem_rdata_in(mem_rdata), .busy_out(busy)
   );

   dmem_arbiter #(.MEM_LATENCY(4)) dut4 (
      .clock(clock), .reset(reset),
      .req0_in(q_req0), .addr0_in(q_addr0), .wdata0_in(q_wdata0), .we0_in(q_we0), .size0_in(q_size0),
      .done0_out(q_done0), .rdata0_out(q_rdata0),
      .req1_in(1'b0), .addr1_in(32'h0), .wdata1_in(32'h0), .we1_in(1'b0), .size1_in(2'b00),
      .done1_out(q_done1), .rdata1_out(q_rdata1),
      .mem_addr_out(q_mem_addr), .mem_wdata_out(q_mem_wdata), .mem_re_out(q_mem_re), .mem_we_out(q_mem_we),
      .mem_size_out(q_mem_size), .mem_rdata_in(q_mem_rdata), .busy_out(q_busy)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   // model state: one transaction described by its grant cycle t0
   int          cyc = 0;
   int          t0  = 0;
   bit          active = 1'b0, granted = 1'b0, win = 1'b0, lg = 1'b1, m_we = 1'b0;
   logic [31:0] m_addr = '0, m_wdata = '0, rdv = '0;
   logic [1:0]  m_size = '0;
   logic [31:0] rd [2];
   bit          exp_busy = 1'b0, exp_re = 1'b0, exp_we = 1'b0;
   bit   [1:0]  exp_done = 2'b00, prev_done = 2'b00;
   logic [31:0] mem [8];

   // inputs applied during the previous cycle
   bit          p_reset;
   bit          p_req [2];
   bit          p_we  [2];
   logic [31:0] p_addr [2];
   logic [31:0] p_wdata [2];
   logic [1:0]  p_size [2];

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic got, input logic exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Advance the model by one cycle using the inputs seen in the previous cycle
   task automatic model_step();
      int off;
      cyc++;
      if (p_reset) begin
         active = 1'b0; granted = 1'b0; lg = 1'b1;
         rd[0] = '0; rd[1] = '0;
         m_addr = '0; m_wdata = '0; m_size = '0; m_we = 1'b0;
      end else if ((!active || (cyc - 1 > t0 + LAT + 2)) && (p_req[0] || p_req[1])) begin
         if (p_req[0] && p_req[1]) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = !lg;
`endif
         end else begin
            win = p_req[1];
         end
         lg = win; t0 = cyc - 1; active = 1'b1; granted = 1'b1;
         m_addr = p_addr[win]; m_wdata = p_wdata[win]; m_size = p_size[win]; m_we = p_we[win];
      end
      off = cyc - t0;
      exp_busy    = active && off >= 1 && off <= LAT + 2;
      exp_re      = active && off == 1 && !m_we;
      exp_we      = active && off == 1 && m_we;
      exp_done[0] = active && off == LAT + 2 && !win;
      exp_done[1] = active && off == LAT + 2 && win;
      if (active && off == LAT + 2 && !m_we) rd[win] = rdv;
   endtask

   // One clock: snapshot inputs, step the model, then drive the memory response for the new cycle
   task automatic tick();
      p_reset = reset;
      p_req[0] = req0; p_addr[0] = addr0; p_wdata[0] = wdata0; p_we[0] = we0; p_size[0] = size0;
      p_req[1] = req1; p_addr[1] = addr1; p_wdata[1] = wdata1; p_we[1] = we1; p_size[1] = size1;
      prev_done = exp_done;
      @(posedge clock);
      #1;
      model_step();
      mem_rdata = $urandom;
      if (active && cyc == t0 + 1 && m_we) mem[m_addr[4:2]] = m_wdata;
      if (active && cyc == t0 + 1 + LAT && !m_we) begin
         mem_rdata = mem[m_addr[4:2]];
         rdv = mem_rdata;
      end
   endtask

   task automatic set_port(input int p, input bit r, input logic [31:0] a, input logic [31:0] d,
                           input bit w, input logic [1:0] s);
      if (p == 0) begin
         req0 = r; addr0 = a; wdata0 = d; we0 = w; size0 = s;
      end else begin
         req1 = r; addr1 = a; wdata1 = d; we1 = w; size1 = s;
      end
   endtask

   // Every-cycle comparison of the main instance against the model
   always @(negedge clock) begin
      if (cmp_en) begin
         check1("busy", busy, exp_busy);
         check1("mem_re", mem_re, exp_re);
         check1("mem_we", mem_we, exp_we);
         check1("done0", done0, exp_done[0]);
         check1("done1", done1, exp_done[1]);
         check32("rdata0", rdata0, rd[0]);
         check32("rdata1", rdata1, rd[1]);
         if (exp_busy || !granted) begin
            check32("mem_addr", mem_addr, m_addr);
            check32("mem_wdata", mem_wdata, m_wdata);
            check32("mem_size", {30'b0, mem_size}, {30'b0, m_size});
         end
      end
   end

   bit gr [4];
   int ng;

   initial begin
      reset = 1'b1;
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      mem_rdata = '0;
      q_req0 = 1'b0; q_we0 = 1'b0; q_addr0 = '0; q_wdata0 = '0; q_size0 = '0; q_mem_rdata = '0;
      rd[0] = '0; rd[1] = '0;
      for (int i = 0; i < 8; i++) mem[i] = $urandom;
      mem[4] = 32'hDEAD_BEEF;

      // reset held two cycles, released with both requests low
      tick();
      cmp_en = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      check1("t1_busy", busy, 1'b0);
      check1("t1_done0", done0, 1'b0);
      check1("t1_mem_re", mem_re, 1'b0);
      check32("t1_rdata0", rdata0, 32'h0);
      check32("t1_mem_addr", mem_addr, 32'h0);
      tick();
      check1("t1_busy_idle", busy, 1'b0);

      // port 0 read of 0x10
      set_port(0, 1, 32'h10, 32'h0, 0, 2'b10);
      tick();
      check1("t2_mem_re", mem_re, 1'b1);
      check32("t2_mem_addr", mem_addr, 32'h10);
      tick();
      check1("t2_mem_re_off", mem_re, 1'b0);
      check1("t2_done_early", done0, 1'b0);
      tick();
      check1("t2_done0", done0, 1'b1);
      check1("t2_done1", done1, 1'b0);
      check32("t2_rdata0", rdata0, 32'hDEAD_BEEF);
      tick();
      set_port(0, 0, 0, 0, 0, 0);
      tick();

      // port 1 write of 0xCAFEF00D to 0x20, size 2
      set_port(1, 1, 32'h20, 32'hCAFE_F00D, 1, 2'b10);
      tick();
      check1("t3_mem_we", mem_we, 1'b1);
      check1("t3_mem_re", mem_re, 1'b0);
      check32("t3_mem_addr", mem_addr, 32'h20);
      check32("t3_mem_wdata", mem_wdata, 32'hCAFE_F00D);
      check32("t3_mem_size", {30'b0, mem_size}, 32'h2);
      tick();
      check1("t3_mem_we_off", mem_we, 1'b0);
      tick();
      check1("t3_done1", done1, 1'b1);
      check1("t3_done0", done0, 1'b0);
      check32("t3_rdata1", rdata1, 32'h0);
      check32("t3_rdata0_kept", rdata0, 32'hDEAD_BEEF);
      tick();
      set_port(1, 0, 0, 0, 0, 0);
      tick();

      // reset during WAIT, then a fresh request
      set_port(0, 1, 32'h10, 32'h0, 0, 2'b10);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check1("t6_done0", done0, 1'b0);
      check1("t6_busy", busy, 1'b0);
      check32("t6_rdata0", rdata0, 32'h0);
      check32("t6_mem_addr", mem_addr, 32'h0);
      tick();
      check1("t6_mem_re", mem_re, 1'b1);
      tick();
      tick();
      check1("t6_done0_fresh", done0, 1'b1);
      check32("t6_rdata0_fresh", rdata0, 32'hDEAD_BEEF);
      tick();
      set_port(0, 0, 0, 0, 0, 0);
      tick();

      // both requests held continuously after reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_port(0, 1, 32'h10, 32'h0, 0, 2'b10);
      set_port(1, 1, 32'h14, 32'h0, 0, 2'b10);
      ng = 0;
      for (int k = 0; k < 4; k++) gr[k] = 1'b0;
      for (int k = 0; k < 40 && ng < 4; k++) begin
         tick();
         if (done0 || done1) begin
            gr[ng] = done1;
            ng++;
         end
      end
      check32("t4_grant_count", ng, 32'd4);
      for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
         check1("t4_grant", gr[k], 1'b0);
`else
         check1("t4_grant", gr[k], k[0]);
`endif
      end
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      tick();
      tick();

      // latency-4 instance: done exactly six cycles after the sample cycle
      q_req0 = 1'b1; q_addr0 = 32'h40; q_wdata0 = 32'h55; q_we0 = 1'b0; q_size0 = 2'b10;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check1("t5_mem_re", q_mem_re, k == 1);
         check1("t5_done0", q_done0, k == 6);
         check1("t5_done1", q_done1, 1'b0);
         if (k == 1) begin
            check1("t5_mem_we", q_mem_we, 1'b0);
            check32("t5_mem_wdata", q_mem_wdata, 32'h55);
            check32("t5_mem_size", {30'b0, q_mem_size}, 32'h2);
         end
         if (k == 2) q_addr0 = 32'hFFFF_FFFC;
         if (k == 4) begin
            check32("t5_mem_addr_stable", q_mem_addr, 32'h40);
            check1("t5_busy", q_busy, 1'b1);
         end
         if (k == 6) begin
            check32("t5_rdata0", q_rdata0, 32'h1234_5678);
            check32("t5_rdata1", q_rdata1, 32'h0);
         end
         q_mem_rdata = (k == 5) ? 32'h1234_5678 : $urandom;
      end
      q_req0 = 1'b0;
      tick();
      check1("t5_done0_after", q_done0, 1'b0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         tick();
         reset = ($urandom_range(0, 249) == 0);
         for (int p = 0; p < 2; p++) begin
            bit cur;
            cur = (p == 0) ? req0 : req1;
            if (p_reset || (prev_done[p] && $urandom_range(0, 3) != 0))
               set_port(p, 0, 0, 0, 0, 0);
            else if (prev_done[p] || (!cur && $urandom_range(0, 2) == 0))
               set_port(p, 1, $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 2)));
         end
      end
      reset = 1'b0;
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) tick();
      check1("end_busy", busy, 1'b0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
